// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file (NRD async reads, NWR sync writes) with a per-register busy scoreboard.
// Optional same-cycle writeback-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   i_du_rs,
  input  logic [NRD-1:0]      i_du_rs_vld,
  output logic [NRD*XLEN-1:0] o_exec_data,
  output logic [NRD-1:0]      o_du_rs_busy,
  input  logic                i_du_issue_en,
  input  logic [AW-1:0]       i_du_issue_rd,
  output logic                o_du_stall,
  input  logic [NWR-1:0]      i_wb_write_en,
  input  logic [NWR*AW-1:0]   i_wb_rd,
  input  logic [NWR*XLEN-1:0] i_wb_data,
  input  logic                i_flush,
  output logic [AW:0]         o_busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic [AW-1:0]   rs_addr [NRD];
  logic [AW-1:0]   wb_addr [NWR];
  logic [XLEN-1:0] wb_word [NWR];

  always_comb begin
    for (int unsigned p = 0; p < NWR; p++) begin
      wb_addr[p] = i_wb_rd[p*AW +: AW];
      wb_word[p] = i_wb_data[p*XLEN +: XLEN];
    end
    for (int unsigned k = 0; k < NRD; k++) begin
      rs_addr[k] = i_du_rs[k*AW +: AW];
    end
  end

  // Later ports overwrite earlier ones, so the highest-index port wins on a collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_wb_write_en[p] && (wb_addr[p] != '0)) begin
        regs_d[wb_addr[p]] = wb_word[p];
      end
    end
  end

  // Priority: flush > issue set > writeback clear > hold.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_wb_write_en[p]) begin
        busy_d[wb_addr[p]] = 1'b0;
      end
    end
    if (i_du_issue_en) begin
      busy_d[i_du_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (i_flush) begin
      busy_d = '0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    o_exec_data  = '0;
    o_du_rs_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      o_exec_data[k*XLEN +: XLEN] = (rs_addr[k] == '0) ? '0 : regs_q[rs_addr[k]];
      o_du_rs_busy[k]             = busy_q[rs_addr[k]] & i_du_rs_vld[k];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < NWR; p++) begin
        if (i_wb_write_en[p] && (wb_addr[p] == rs_addr[k]) && (rs_addr[k] != '0)) begin
          o_exec_data[k*XLEN +: XLEN] = wb_word[p];
          // A same-cycle issue to this register is a new producer, so the hazard stands.
          if (!(i_du_issue_en && (i_du_issue_rd == rs_addr[k]))) begin
            o_du_rs_busy[k] = 1'b0;
          end
        end
      end
`endif
    end
  end

  assign o_du_stall = (|o_du_rs_busy) |
                      (i_du_issue_en & busy_q[i_du_issue_rd] & (i_du_issue_rd != '0));
  assign o_busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default 32x32, 2R/2W); follows
// REGFILE_BYPASS_EN for the forwarding-dependent expectations.
module tb_regfile_mp_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD*AW-1:0]   i_du_rs;
  logic [NRD-1:0]      i_du_rs_vld;
  logic [NRD*XLEN-1:0] o_exec_data;
  logic [NRD-1:0]      o_du_rs_busy;
  logic                i_du_issue_en;
  logic [AW-1:0]       i_du_issue_rd;
  logic                o_du_stall;
  logic [NWR-1:0]      i_wb_write_en;
  logic [NWR*AW-1:0]   i_wb_rd;
  logic [NWR*XLEN-1:0] i_wb_data;
  logic                i_flush;
  logic [AW:0]         o_busy_cnt;

  int errors = 0;
  int checks = 0;

  regfile_mp_sb #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_du_rs      (i_du_rs),
    .i_du_rs_vld  (i_du_rs_vld),
    .o_exec_data  (o_exec_data),
    .o_du_rs_busy (o_du_rs_busy),
    .i_du_issue_en(i_du_issue_en),
    .i_du_issue_rd(i_du_issue_rd),
    .o_du_stall   (o_du_stall),
    .i_wb_write_en(i_wb_write_en),
    .i_wb_rd      (i_wb_rd),
    .i_wb_data    (i_wb_data),
    .i_flush      (i_flush),
    .o_busy_cnt   (o_busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_du_issue_en = 1'b0;
    i_du_issue_rd = '0;
    i_wb_write_en = '0;
    i_wb_rd       = '0;
    i_wb_data     = '0;
    i_flush       = 1'b0;
  endtask

  task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [1:0] vld);
    i_du_rs     = {a1, a0};
    i_du_rs_vld = vld;
    #1;
  endtask

  task automatic wb(input logic [1:0] en, input logic [AW-1:0] rd0, input logic [31:0] d0,
                    input logic [AW-1:0] rd1, input logic [31:0] d1);
    i_wb_write_en = en;
    i_wb_rd       = {rd1, rd0};
    i_wb_data     = {d1, d0};
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    i_du_issue_en = 1'b1;
    i_du_issue_rd = rd;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    i_du_rs     = '0;
    i_du_rs_vld = '0;
    #3;
    chk("reset_busy_cnt", 64'(o_busy_cnt), 64'd0);
    chk("reset_stall", 64'(o_du_stall), 64'd0);
    #5 rstn = 1'b1;
    tick();

    // 1: every register reads zero after reset
    for (int r = 0; r < 32; r += 2) begin
      set_rs(AW'(r), AW'(r + 1), 2'b11);
      chk("init_read", 64'(o_exec_data), 64'd0);
    end
    chk("init_rs_busy", 64'(o_du_rs_busy), 64'd0);
    chk("init_stall", 64'(o_du_stall), 64'd0);

    // 2: RAW hazard on x5 and its resolution by writeback
    issue(5'd5);
    tick();
    idle_inputs();
    set_rs(5'd5, 5'd0, 2'b01);
    chk("raw_rs_busy", 64'(o_du_rs_busy), 64'd1);
    chk("raw_stall", 64'(o_du_stall), 64'd1);
    chk("raw_busy_cnt", 64'(o_busy_cnt), 64'd1);
    wb(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_same_cycle_data", 64'(o_exec_data[31:0]), 64'hDEADBEEF);
    chk("wb_same_cycle_stall", 64'(o_du_stall), 64'd0);
`else
    chk("wb_same_cycle_data", 64'(o_exec_data[31:0]), 64'd0);
    chk("wb_same_cycle_stall", 64'(o_du_stall), 64'd1);
`endif
    tick();
    idle_inputs();
    #1;
    chk("wb_next_data", 64'(o_exec_data[31:0]), 64'hDEADBEEF);
    chk("wb_next_stall", 64'(o_du_stall), 64'd0);
    chk("wb_next_busy_cnt", 64'(o_busy_cnt), 64'd0);

    // 3: dual write collision, then x0 write and rd=0 issue
    wb(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    tick();
    idle_inputs();
    set_rs(5'd7, 5'd5, 2'b00);
    chk("dual_wb_x7_x5", 64'(o_exec_data), {32'hDEADBEEF, 32'h22});
    wb(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0);
    issue(5'd0);
    tick();
    idle_inputs();
    set_rs(5'd0, 5'd7, 2'b11);
    chk("x0_reads_zero", 64'(o_exec_data), {32'h22, 32'h0});
    chk("x0_busy_cnt", 64'(o_busy_cnt), 64'd0);
    chk("x0_rs_busy", 64'(o_du_rs_busy), 64'd0);

    // 4: issue beats same-edge writeback; WAW stall
    issue(5'd9);
    wb(2'b10, 5'd0, 32'd0, 5'd9, 32'h99);
    tick();
    idle_inputs();
    set_rs(5'd0, 5'd9, 2'b10);
    chk("issue_beats_wb_busy", 64'(o_du_rs_busy), 64'b10);
    chk("issue_beats_wb_cnt", 64'(o_busy_cnt), 64'd1);
    chk("issue_beats_wb_data", 64'(o_exec_data[63:32]), 64'h99);
    set_rs(5'd0, 5'd9, 2'b00);
    issue(5'd9);
    #1;
    chk("waw_stall", 64'(o_du_stall), 64'd1);
    idle_inputs();
    #1;
    chk("waw_released", 64'(o_du_stall), 64'd0);

    // 5: flush beats a same-cycle issue and leaves data intact
    wb(2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2);
    tick();
    wb(2'b01, 5'd3, 32'hA3, 5'd0, 32'd0);
    tick();
    idle_inputs();
    for (int r = 1; r <= 3; r++) begin
      issue(AW'(r));
      tick();
    end
    idle_inputs();
    #1;
    chk("pre_flush_cnt", 64'(o_busy_cnt), 64'd4);
    i_flush = 1'b1;
    issue(5'd4);
    tick();
    idle_inputs();
    set_rs(5'd4, 5'd9, 2'b11);
    chk("flush_cnt", 64'(o_busy_cnt), 64'd0);
    chk("flush_rs_busy", 64'(o_du_rs_busy), 64'd0);
    chk("flush_stall", 64'(o_du_stall), 64'd0);
    set_rs(5'd1, 5'd2, 2'b11);
    chk("flush_x1_x2", 64'(o_exec_data), {32'hA2, 32'hA1});
    set_rs(5'd3, 5'd0, 2'b01);
    chk("flush_x3", 64'(o_exec_data[31:0]), 64'hA3);

    // 6: async reset in the middle of a write
    wb(2'b01, 5'd10, 32'h5, 5'd0, 32'd0);
    tick();
    idle_inputs();
    for (int r = 10; r <= 12; r++) begin
      issue(AW'(r));
      tick();
    end
    idle_inputs();
    set_rs(5'd10, 5'd11, 2'b11);
    chk("pre_reset_cnt", 64'(o_busy_cnt), 64'd3);
    chk("pre_reset_x10", 64'(o_exec_data[31:0]), 64'h5);
    chk("pre_reset_stall", 64'(o_du_stall), 64'd1);
    wb(2'b01, 5'd13, 32'h77, 5'd0, 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_data", 64'(o_exec_data), 64'd0);
    chk("async_rst_cnt", 64'(o_busy_cnt), 64'd0);
    chk("async_rst_rs_busy", 64'(o_du_rs_busy), 64'd0);
    chk("async_rst_stall", 64'(o_du_stall), 64'd0);
    idle_inputs();
    tick();
    rstn = 1'b1;
    set_rs(5'd13, 5'd12, 2'b11);
    chk("lost_write_x13", 64'(o_exec_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
